// File: rtl/nt_node_signature_checker_pkg.sv
// Shared types, default MISR constants and the MISR step used by the signature checker.
// Pure combinational helpers, no state and no handshaking.
package nt_sig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          SIG_W_DEF  = 16;
    localparam logic [15:0] POLY_DEF   = 16'h1021;
    localparam logic [15:0] SEED_DEF   = 16'hFFFF;
    localparam int          MISR_MAX_W = 64;

    // Operands are carried at MISR_MAX_W and masked to the live width w (w < 64).
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] resp_ext,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        mask = (64'd1 << w) - 64'd1;
        nxt  = (sig << 1) & mask;
        if (|(sig & (64'd1 << (w - 1)))) begin
            nxt = nxt ^ poly;
        end
        return (nxt ^ resp_ext) & mask;
    endfunction

endpackage

// File: rtl/nt_node_signature_checker_if.sv
// Control/response bundle between the subcircuit harness and the signature checker.
// slave = checker side, master = driver side; no backpressure, samples are taken when presented.
interface nt_node_signature_checker_if #(
    parameter int RESP_W = 1,
    parameter int SIG_W  = 16
);
    logic              start;
    logic              clear;
    logic [RESP_W-1:0] resp;
    logic              resp_valid;
    logic [SIG_W-1:0]  golden;
    logic              busy;
    logic              done;
    logic              match;
    logic              mismatch;
    logic [SIG_W-1:0]  signature;

    modport master (
        output start, clear, resp, resp_valid, golden,
        input  busy, done, match, mismatch, signature
    );

    modport slave (
        input  start, clear, resp, resp_valid, golden,
        output busy, done, match, mismatch, signature
    );
endinterface

// File: rtl/nt_node_signature_checker_misr.sv
// Signature register: load wins over enable, enable applies one MISR step; 1-cycle update.
// No backpressure; sig_next is exposed so the owner can compare the post-step value same-edge.
module nt_misr
    import nt_sig_pkg::*;
#(
    parameter int               RESP_W = 1,
    parameter int               SIG_W  = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY   = POLY_DEF,
    parameter logic [SIG_W-1:0] SEED   = SEED_DEF
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig,
    output logic [SIG_W-1:0]  sig_next
);

    always_comb begin
        sig_next = SIG_W'(misr_step(64'(sig), 64'(resp), 64'(POLY), SIG_W));
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/nt_node_signature_checker.sv
// Compacts NUM_CYCLES valid response samples into a MISR signature and checks it against golden.
// done/match rise 1 cycle after the last sample edge; no backpressure, idle resp_valid cycles just stall.
module nt_node_signature_checker
    import nt_sig_pkg::*;
#(
    parameter int               RESP_W     = 1,
    parameter int               SIG_W      = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY       = POLY_DEF,
    parameter logic [SIG_W-1:0] SEED       = SEED_DEF,
    parameter int               NUM_CYCLES = 100,
    parameter int               CNT_W      = 7
) (
    input  logic                        CLK,
    input  logic                        RSTB,
    nt_node_signature_checker_if.slave  bus
);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              done_q;
    logic              match_q;
    logic              misr_load;
    logic              misr_en;
    logic              last_sample;
    logic [SIG_W-1:0]  sig;
    logic [SIG_W-1:0]  sig_next;

    // clear and a restart both reseed; start is only honoured outside RUN.
    assign misr_load   = bus.clear | (bus.start & (state != RUN));
    assign misr_en     = (state == RUN) & bus.resp_valid;
    assign last_sample = misr_en & (count == CNT_W'(NUM_CYCLES - 1));

    nt_misr #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .load     (misr_load),
        .en       (misr_en),
        .resp     (bus.resp),
        .sig      (sig),
        .sig_next (sig_next)
    );

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state   <= IDLE;
            count   <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else if (bus.clear) begin
            state   <= IDLE;
            count   <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (last_sample) begin
                        state   <= DONE;
                        count   <= '0;
                        done_q  <= 1'b1;
                        match_q <= (sig_next == bus.golden);
                    end else if (misr_en) begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        count   <= '0;
                        done_q  <= 1'b0;
                        match_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.match     = match_q;
    assign bus.mismatch  = done_q & ~match_q;
    assign bus.signature = sig;

endmodule

// File: tb/tb_nt_node_signature_checker.sv
// Bench for the signature checker: directed scenarios plus random traffic against a window-level model.
module tb_nt_node_signature_checker;

    localparam int NCYC = 4;

    logic CLK = 1'b0;
    logic RSTB;
    always #5 CLK = ~CLK;

    nt_node_signature_checker_if #(.RESP_W(1), .SIG_W(16)) bus ();

    nt_node_signature_checker #(
        .RESP_W     (1),
        .SIG_W      (16),
        .POLY       (16'h1021),
        .SEED       (16'hFFFF),
        .NUM_CYCLES (NCYC),
        .CNT_W      (3)
    ) dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Window-level model: mode 0 idle, 1 collecting, 2 finished.
    int          m_mode;
    int          m_cnt;
    logic [15:0] m_sig;
    bit          m_done;
    bit          m_match;

    function automatic logic [15:0] mstep(input logic [15:0] s, input bit r);
        int v;
        v = (int'(s) * 2) % 65536;
        if (s >= 16'h8000) v = v ^ 'h1021;
        v = v ^ int'(r);
        return 16'(v);
    endfunction

    always @(posedge CLK or negedge RSTB) begin
        if (!RSTB || bus.clear) begin
            m_mode = 0; m_cnt = 0; m_sig = 16'hFFFF; m_done = 0; m_match = 0;
        end else if (m_mode != 1 && bus.start) begin
            m_mode = 1; m_cnt = 0; m_sig = 16'hFFFF; m_done = 0; m_match = 0;
        end else if (m_mode == 1 && bus.resp_valid) begin
            m_sig = mstep(m_sig, bus.resp[0]);
            m_cnt++;
            if (m_cnt == NCYC) begin
                m_mode = 2; m_cnt = 0; m_done = 1; m_match = (m_sig == bus.golden);
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTB === 1'b1) begin
            chk("busy",      32'(bus.busy),      32'(m_mode == 1));
            chk("done",      32'(bus.done),      32'(m_done));
            chk("match",     32'(bus.match),     32'(m_match));
            chk("mismatch",  32'(bus.mismatch),  32'(m_done && !m_match));
            chk("signature", 32'(bus.signature), 32'(m_sig));
        end
    end

    // Present inputs at the falling edge, return just after the rising edge that consumed them.
    task automatic step(input bit st, input bit cl, input bit rv, input bit r);
        @(negedge CLK);
        bus.start = st; bus.clear = cl; bus.resp_valid = rv; bus.resp = r;
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] exp_t1 [4];

    initial begin
        exp_t1[0] = 16'hEFDF; exp_t1[1] = 16'hCF9F; exp_t1[2] = 16'h8F1F; exp_t1[3] = 16'h0E1F;
        RSTB = 1'b0;
        bus.start = 0; bus.clear = 0; bus.resp_valid = 0; bus.resp = 0; bus.golden = 16'h0E1F;
        #12;
        chk("rst_sig",  32'(bus.signature), 32'h0000FFFF);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mism", 32'(bus.mismatch), 32'd0);
        @(negedge CLK); RSTB = 1'b1;

        // zero stream, expected match
        step(1, 0, 0, 0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0);
            chk($sformatf("t1_sig%0d", i), 32'(bus.signature), 32'(exp_t1[i]));
        end
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_match", 32'(bus.match), 32'd1);
        chk("t1_mism", 32'(bus.mismatch), 32'd0);

        // all-ones stream, restart from DONE
        step(1, 0, 0, 0);
        chk("t2_reload", 32'(bus.signature), 32'h0000FFFF);
        chk("t2_done0", 32'(bus.done), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        chk("t2_sig", 32'(bus.signature), 32'h00000E10);
        chk("t2_mism", 32'(bus.mismatch), 32'd1);
        chk("t2_match", 32'(bus.match), 32'd0);

        // gapped valid
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, i[0], 0);
            chk("t3_busy", 32'(bus.busy), 32'(i != 7));
            chk("t3_done", 32'(bus.done), 32'(i == 7));
        end
        chk("t3_sig", 32'(bus.signature), 32'h00000E1F);

        // start during RUN ignored
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("t4_nodone", 32'(bus.done), 32'd0);
        step(0, 0, 1, 0);
        chk("t4_sig", 32'(bus.signature), 32'h00000E1F);
        chk("t4_done", 32'(bus.done), 32'd1);
        step(1, 0, 0, 0);
        chk("t4_reload", 32'(bus.signature), 32'h0000FFFF);
        chk("t4_done0", 32'(bus.done), 32'd0);

        // clear with final sample, clear with start
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_sig", 32'(bus.signature), 32'h0000FFFF);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        step(1, 1, 0, 0);
        chk("t5_idle", 32'(bus.busy), 32'd0);
        step(0, 0, 0, 0);

        // async reset mid-window
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        bus.resp_valid = 0;
        @(negedge CLK); #2; RSTB = 1'b0; #1;
        chk("t6_sig", 32'(bus.signature), 32'h0000FFFF);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        @(negedge CLK); RSTB = 1'b1;
        step(0, 0, 1, 0);
        chk("t6_idle", 32'(bus.busy), 32'd0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("t6_sig_end", 32'(bus.signature), 32'h00000E1F);
        chk("t6_match", 32'(bus.match), 32'd1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            bit st, cl, rv, r;
            st = ($urandom % 6) == 0;
            cl = ($urandom % 40) == 0;
            rv = $urandom % 2;
            r  = $urandom % 2;
            if (m_mode == 1 && m_cnt == NCYC - 1 && ($urandom % 2))
                bus.golden = mstep(m_sig, r);
            else
                bus.golden = 16'($urandom);
            step(st, cl, rv, r);
        end

        step(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nt_node_signature_checker.md
Name: nt_node_signature_checker

Overview:
- Response-side companion to the Nt_Node subcircuit benchmarks: consumes a subcircuit output stream over a fixed test window and compacts it into a MISR signature.
- Compares the final signature against a golden value and flags a mismatch as possible trojan activation.
- Sits between the subcircuit under test and the detection controller; one instance per observed output bundle.

Parameters:
- RESP_W, 1, width of the observed response bus (single-output subcircuits use 1).
- SIG_W, 16, signature width; must satisfy SIG_W > RESP_W.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SEED, 16'hFFFF, signature value loaded at reset and on every start.
- NUM_CYCLES, 100, number of valid response samples per test window (>= 1).
- CNT_W, 7, counter width; must satisfy 2^CNT_W >= NUM_CYCLES.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTB  input  1  asynchronous active-low reset.
- start  input  1  begin a test window; honoured in IDLE or DONE only.
- clear  input  1  synchronous abort; returns to IDLE and takes priority over start.
- resp  input  RESP_W  subcircuit response sample.
- resp_valid  input  1  resp is sampled this cycle.
- golden  input  SIG_W  expected signature; sampled on the DONE-entry cycle.
- busy  output  1  high in RUN.
- done  output  1  high in DONE, held until start or clear.
- match  output  1  signature equals golden; valid while done=1.
- mismatch  output  1  done & ~match.
- signature  output  SIG_W  current MISR contents.

Behaviour:
- Reset (RSTB=0, asynchronous) sets:
  - state = IDLE, signature = SEED, count = 0.
  - busy = 0, done = 0, match = 0, mismatch = 0.
- States are IDLE, RUN and DONE. All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- IDLE:
  - start=1 moves to RUN; signature <= SEED and count <= 0.
  - resp_valid is ignored.
- RUN:
  - busy = 1.
  - On each cycle with resp_valid=1, apply the MISR step and set count <= count+1.
  - Cycles with resp_valid=0 hold signature and count; there is no timeout.
  - The sample taken when count == NUM_CYCLES-1 is the last one. On that edge the state moves to DONE and count resets to 0.
- MISR step:
  - fb = signature[SIG_W-1].
  - next = (signature << 1) truncated to SIG_W bits, XOR (fb ? POLY : 0), XOR zero-extend(resp).
- DONE entry:
  - match <= (next signature == golden), compared in the same edge as the last sample.
  - done = 1 and busy = 0 from the following cycle.
- DONE:
  - signature, match and done are held stable.
  - resp_valid is ignored.
  - start=1 restarts directly into RUN (SEED reload, done <= 0, match <= 0).
- start during RUN is ignored.
- clear=1 in any state moves to IDLE next edge, sets signature <= SEED, count <= 0, done <= 0, match <= 0. clear wins over a simultaneous start and over a final sample.
- RSTB asserted mid-window discards the window; after release the block is in IDLE and needs a new start.
- Latency: done rises 1 cycle after the edge that takes the NUM_CYCLES-th valid sample.
- Width rules:
  - resp is zero-extended into bits [RESP_W-1:0].
  - count never wraps, because it resets on the last sample.
  - Compare is full SIG_W equality.

Decomposition:
- Shared package nt_sig_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default SIG_W, POLY and SEED constants;
  - a pure function misr_step(sig, resp) implementing the step above.
- One sub-module, nt_misr (signature register with load/enable and the step logic). FSM and counter stay in the top.

Test Plan:
All scenarios use SIG_W=16, POLY=16'h1021, SEED=16'hFFFF, NUM_CYCLES=4, RESP_W=1.
- Reset, then start, then 4 cycles of valid resp=0 with golden=16'h0E1F -> signature steps EFDF, CF9F, 8F1F, 0E1F; done=1, match=1, mismatch=0 one cycle after the 4th sample.
- Same run with resp=1 on all 4 samples and golden=16'h0E1F -> signature 16'h0E10, done=1, match=0, mismatch=1.
- resp=0 stream with resp_valid low on alternate cycles (8 cycles total) -> same 16'h0E1F; busy high for the full span; done asserted exactly after the 4th valid sample.
- start pulsed again during RUN after 2 samples -> ignored; window completes with the 4 original samples; start in DONE -> signature reloads FFFF, done drops next cycle.
- clear together with the 4th valid sample -> IDLE, done stays 0, signature=FFFF; clear together with start in IDLE -> remains IDLE.
- RSTB low for 1 cycle after sample 2 -> outputs go to reset values immediately (asynchronously); a fresh start plus 4 zero samples yields 16'h0E1F.
